// File: rtl/block_compare_seq.sv
// block_compare_seq
// -----------------------------------------------------------------------------
// Sequencer for the Z80 block-compare instructions CPI, CPD, CPIR and CPDR.
// It fetches one byte per iteration over a req/ack memory port. It then uses
// the external ALU adder for three operations: the A - (HL) compare, the HL
// step and the BC decrement. When the sequence finishes it presents the final
// HL, BC and F values.
//
// Optional feature: define BLOCK_CMP_IRQ_EN to let a pending interrupt break
// a repeating instruction after the current iteration. In that case the
// sequencer finishes with rewind = 1 so that the decoder re-executes the
// instruction.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   start, mode        start pulse (IDLE only); mode[0] = decrement HL,
//                      mode[1] = repeat
//   a_in, hl_in,       register values latched on start
//   bc_in, f_in        (only f_in[0], the carry, is used)
//   irq_pending        interrupt pending (used only with BLOCK_CMP_IRQ_EN)
//   mem_req/addr/ack/  byte read port; data is valid in the ack cycle
//   mem_data
//   add_a/b/opp/size   adder operands: opp 1 = subtract, size 1 = 16-bit
//   add_out, add_flags adder result and flags (SZXHXPNC)
//   busy, done         busy from the cycle after start through DONE;
//                      done is a one-cycle completion pulse
//   hl_out, bc_out,    final register values, updated on entry to DONE
//   f_out
//   rewind             valid with done: the decoder must re-execute (PC -= 2)
module block_compare_seq #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [7:0]        a_in,
  input  logic [ADDR_W-1:0] hl_in,
  input  logic [ADDR_W-1:0] bc_in,
  input  logic [7:0]        f_in,
  input  logic              irq_pending,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [15:0]       add_a,
  output logic [15:0]       add_b,
  output logic              add_opp,
  output logic              add_size,
  input  logic [15:0]       add_out,
  input  logic [7:0]        add_flags,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] hl_out,
  output logic [ADDR_W-1:0] bc_out,
  output logic [7:0]        f_out,
  output logic              rewind
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CMP   = 3'd2,
    S_HLUPD = 3'd3,
    S_BCDEC = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        a_q, a_d;
  logic [ADDR_W-1:0] hl_q, hl_d;
  logic [ADDR_W-1:0] bc_q, bc_d;
  logic              c_q, c_d;
  logic [1:0]        mode_q, mode_d;
  logic [7:0]        byte_q, byte_d;
  // Compare flags kept from the CMP step: {S, Z, bit5, H, bit3}.
  logic [4:0]        cmpf_q, cmpf_d;
  logic [ADDR_W-1:0] hl_out_q, hl_out_d;
  logic [ADDR_W-1:0] bc_out_q, bc_out_d;
  logic [7:0]        f_out_q, f_out_d;
  logic              rewind_q, rewind_d;

  logic              pv_s;
  logic              repeat_s;
  logic              irq_stop_s;
  logic [7:0]        f_new_s;
  logic              unused_s;

`ifdef BLOCK_CMP_IRQ_EN
  assign irq_stop_s = irq_pending;
  assign unused_s   = ^{f_in[7:1], add_flags[2:0]};
`else
  assign irq_stop_s = 1'b0;
  assign unused_s   = ^{f_in[7:1], add_flags[2:0], irq_pending};
`endif

  assign mem_req  = (state_q == S_READ);
  assign mem_addr = hl_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign hl_out   = hl_out_q;
  assign bc_out   = bc_out_q;
  assign f_out    = f_out_q;
  assign rewind   = rewind_q;

  // Next-state, adder drive and register-update logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    hl_d     = hl_q;
    bc_d     = bc_q;
    c_d      = c_q;
    mode_d   = mode_q;
    byte_d   = byte_q;
    cmpf_d   = cmpf_q;
    hl_out_d = hl_out_q;
    bc_out_d = bc_out_q;
    f_out_d  = f_out_q;
    rewind_d = 1'b0;
    add_a    = 16'h0000;
    add_b    = 16'h0000;
    add_opp  = 1'b0;
    add_size = 1'b0;
    pv_s     = 1'b0;
    repeat_s = 1'b0;
    f_new_s  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          hl_d    = hl_in;
          bc_d    = bc_in;
          c_d     = f_in[0];
          mode_d  = mode;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (mem_ack) begin
          byte_d  = mem_data;
          state_d = S_CMP;
        end else begin
          state_d = S_READ;
        end
      end
      S_CMP: begin
        add_a   = {8'h00, a_q};
        add_b   = {8'h00, byte_q};
        add_opp = 1'b1;
        cmpf_d  = {add_flags[7], add_flags[6], add_flags[5], add_flags[4], add_flags[3]};
        state_d = S_HLUPD;
      end
      S_HLUPD: begin
        add_a    = 16'(hl_q);
        add_b    = 16'h0001;
        add_opp  = mode_q[0];
        add_size = 1'b1;
        hl_d     = add_out[ADDR_W-1:0];
        state_d  = S_BCDEC;
      end
      S_BCDEC: begin
        add_a    = 16'(bc_q);
        add_b    = 16'h0001;
        add_opp  = 1'b1;
        add_size = 1'b1;
        bc_d     = add_out[ADDR_W-1:0];
        pv_s     = (add_out[ADDR_W-1:0] != '0);
        f_new_s  = {cmpf_q, pv_s, 1'b1, c_q};
        // Keep repeating only while no match has occurred and the count is nonzero.
        repeat_s = mode_q[1] & ~cmpf_q[3] & pv_s;
        if (repeat_s && !irq_stop_s) begin
          state_d = S_READ;
        end else begin
          // Commit the completed iteration; an interrupt break asks for a re-execute.
          hl_out_d = hl_q;
          bc_out_d = add_out[ADDR_W-1:0];
          f_out_d  = f_new_s;
          rewind_d = repeat_s & irq_stop_s;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= 8'h00;
      hl_q     <= '0;
      bc_q     <= '0;
      c_q      <= 1'b0;
      mode_q   <= 2'b00;
      byte_q   <= 8'h00;
      cmpf_q   <= 5'b00000;
      hl_out_q <= '0;
      bc_out_q <= '0;
      f_out_q  <= 8'h00;
      rewind_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      hl_q     <= hl_d;
      bc_q     <= bc_d;
      c_q      <= c_d;
      mode_q   <= mode_d;
      byte_q   <= byte_d;
      cmpf_q   <= cmpf_d;
      hl_out_q <= hl_out_d;
      bc_out_q <= bc_out_d;
      f_out_q  <= f_out_d;
      rewind_q <= rewind_d;
    end
  end

endmodule
